calc_result_bcd: RTL
====================

// Module: calc_result_bcd
// PURPOSE
//  Downstream stage of the specialized-multiplier calculator. It takes the calculator's
//  4-bit result through a valid/ready handshake and converts it to two BCD digits with
//  a sequential shift-add-3 (double-dabble) engine. Results are buffered in a small FIFO
//  for the display/readout stage. One clock; reset is asynchronous and active-low.
// PARAMETERS
//  DATA_W      4  width of in_data; legal range 1..6, so the maximum value 63 gives tens <= 6
//  FIFO_DEPTH  2  number of converted results held; legal range 2..8
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous active-low reset
//  in_valid  in   1       in_data is valid this cycle
//  in_ready  out  1       stage can accept; equals (state==IDLE)
//  in_data   in   DATA_W  calculator result, unsigned binary
//  out_valid out  1       FIFO not empty; out_tens/out_ones hold the head entry
//  out_ready in   1       consumer takes the head entry this cycle
//  out_tens  out  4       BCD tens digit of the head entry
//  out_ones  out  4       BCD ones digit of the head entry
//  busy      out  1       (state!=IDLE) || (FIFO count!=0)
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; FIFO pointers and count = 0; conversion registers = 0.
//   - out_valid=0, out_tens=0, out_ones=0, busy=0, in_ready=1.
//  FSM states and transitions:
//   - IDLE: on in_valid&&in_ready, latch in_data into the shift register, clear the BCD
//     accumulator and the bit counter, go to CONV. Otherwise stay in IDLE.
//   - CONV: each cycle, add 3 to any BCD nibble >= 5, then shift {tens,ones,bin} left by 1.
//     After exactly DATA_W shifts, go to DONE.
//   - DONE: push {tens,ones} into the FIFO when (count<FIFO_DEPTH) || pop this cycle, then
//     go to IDLE. Otherwise stall in DONE, holding the result.
//  Latency:
//   - The value accepted at edge E0 is written at edge E(DATA_W+1).
//   - out_valid rises after that edge when the FIFO was empty (5 cycles for DATA_W=4).
//  Throughput: one input per DATA_W+2 cycles; in_ready is low throughout CONV and DONE.
//  FIFO:
//   - pop = out_valid && out_ready.
//   - Read/write pointers wrap modulo FIFO_DEPTH.
//   - Simultaneous push and pop when full is allowed: count is unchanged, no data is lost.
//   - Simultaneous push and pop when empty is impossible, because out_valid is 0.
//   - Head data is stable while out_valid && !out_ready.
//   - out_ready while empty is ignored.
//  Width rules:
//   - The BCD accumulator is 8 bits {tens,ones}.
//   - Values above 9 carry into tens: 15 -> tens=1, ones=5.
//   - Input bits beyond DATA_W do not exist; no value is out of range.
//  Reset mid-operation: an in-flight conversion and all FIFO contents are discarded
//   immediately; the first cycle after release is IDLE with in_ready=1.
//  in_valid while in_ready=0 is not accepted; upstream must hold the value.
// TESTING
//  1. Reset, then in_data=4'd9 with out_ready=1 -> out_valid high 5 cycles later;
//     tens=0, ones=9; busy falls the next cycle.
//  2. Sweep in_data 0..15 with out_ready=1 -> each BCD pair matches value/10, value%10
//     (15 -> 1,5; 10 -> 1,0; 0 -> 0,0).
//  3. Hold out_ready=0 and send 11, 13, 7 -> FIFO holds {1,1},{1,3}; the third result
//     stalls in DONE with in_ready=0. Release out_ready -> outputs appear in order 11, 13, 7.
//  4. FIFO full with a DONE pending, out_ready=1 for one cycle -> pop and push on the same
//     edge; count stays 2; the head becomes 13.
//  5. Assert rst_n low 2 cycles into a conversion of 12 with 1 entry queued -> out_valid=0
//     and busy=0 immediately; after release, input 3 yields 0,3 with no stale data.

Source files
------------

// File: rtl/calc_result_bcd.sv
// Result-to-BCD stage: accepts a binary result, converts it with a shift-add-3 engine
// and queues {tens,ones} pairs in a small FIFO for the readout stage.
//
// state | meaning
// IDLE  | waiting for a result, in_ready high
// CONV  | one shift-add-3 step per cycle, DATA_W steps in total
// DONE  | conversion finished, waiting for FIFO room (or a same-cycle pop)
module calc_result_bcd #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_tens,
  output logic [3:0]        out_ones,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] bin;
  logic [7:0]        bcd;
  logic [7:0]        bcd_adj;
  logic [CNT_W-1:0]  cnt;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the new result when the head leaves on the same edge.
  assign push      = (state == DONE) && ((count < CW'(FIFO_DEPTH)) || pop);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE) || (count != '0);
  assign out_tens  = mem[rd_ptr][7:4];
  assign out_ones  = mem[rd_ptr][3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin   <= in_data;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[6:0], bin[DATA_W-1]};
          bin <= bin << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= DONE;
        end
        DONE: begin
          if (push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bcd;
        wr_ptr      <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
